// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit display scanner.
// Digit index, scan state enum and anode helper.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        ON
    } scan_state_t;

    // Active-low one-hot anode pattern for a digit index
    function automatic logic [NUM_DIGITS-1:0] anode_sel_n(digit_idx_t i);
        return ~(4'b0001 << i);
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-digit slot counter for the display scanner.
// Emits slot_start / gap_end / slot_end strobes; cleared when disabled.
module scan_slot_timer
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 2500,
    parameter int DEAD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic idle,
    output logic slot_start,
    output logic gap_end,
    output logic slot_end
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
    localparam bit HAS_GAP = (DEAD_CYCLES > 0);
    localparam logic [CW-1:0] GAP_LAST =
        CW'(HAS_GAP ? DEAD_CYCLES - 1 : 0);

    logic [CW-1:0] cnt;

    // Count within a slot; an idle scanner parks the count at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || idle || slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign slot_end   = (cnt == LAST);
    assign gap_end    = HAS_GAP && (cnt == GAP_LAST);
    // High on the edge that opens a new slot
    assign slot_start = en && (idle || slot_end);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed 4-digit BCD display scanner with dead time and blink.
// Optional macro LEADING_ZERO_BLANK_EN also blanks a zero hour-tens digit.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 2500,
    parameter int DEAD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  blink_mask,
    input  logic        blink_phase,
    output logic [3:0]  bcd_out,
    output logic [3:0]  anode_n,
    output logic [1:0]  digit_sel,
    output logic        frame_start
);

    localparam bit HAS_GAP = (DEAD_CYCLES > 0);

    scan_state_t state;
    digit_idx_t  idx;
    logic [15:0] shadow;
    logic        blank;

    logic        slot_start;
    logic        gap_end;
    logic        slot_end;

    digit_idx_t  nidx;
    logic [15:0] nshadow;
    logic        nblank;
    logic [3:0]  nbcd;

    scan_slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .idle       (state == IDLE),
        .slot_start (slot_start),
        .gap_end    (gap_end),
        .slot_end   (slot_end)
    );

    // Values the next slot will use if a slot opens on this edge
    always_comb begin
        nidx    = (state == IDLE) ? '0 : idx + 1'b1;
        nshadow = (nidx == '0) ? digits : shadow;
        nblank  = blink_mask[nidx] & blink_phase;
`ifdef LEADING_ZERO_BLANK_EN
        if (nidx == 2'd3 && nshadow[15:12] == 4'd0) begin
            nblank = 1'b1;
        end
`endif
        nbcd    = nshadow[DIGIT_W*nidx +: DIGIT_W];
    end

    // Scan FSM with snapshot, blank latch and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            shadow      <= '0;
            blank       <= 1'b0;
            anode_n     <= ANODES_OFF;
            bcd_out     <= '0;
            digit_sel   <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            state       <= IDLE;
            idx         <= '0;
            blank       <= 1'b0;
            anode_n     <= ANODES_OFF;
            bcd_out     <= shadow[3:0];
            digit_sel   <= '0;
            frame_start <= 1'b0;
        end else if (slot_start) begin
            idx         <= nidx;
            shadow      <= nshadow;
            blank       <= nblank;
            bcd_out     <= nbcd;
            digit_sel   <= nidx;
            frame_start <= (nidx == '0);
            if (HAS_GAP) begin
                state   <= GAP;
                anode_n <= ANODES_OFF;
            end else begin
                state   <= ON;
                anode_n <= nblank ? ANODES_OFF : anode_sel_n(nidx);
            end
        end else begin
            frame_start <= 1'b0;
            if (state == GAP && gap_end) begin
                state   <= ON;
                anode_n <= blank ? ANODES_OFF : anode_sel_n(idx);
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux (REFRESH_DIV=4, DEAD_CYCLES=1).
// Directed steps then random traffic against a slot-arithmetic model.
module tb_display_scan_mux;

    localparam int RD = 4;
    localparam int DC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic        blink_phase;
    logic [3:0]  bcd_out;
    logic [3:0]  anode_n;
    logic [1:0]  digit_sel;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    bit         active = 1'b0;
    int         k      = 0;
    int         idx_m  = 0;
    int         pos_m  = 0;
    logic [3:0] snap [4];
    bit         blank_m;
    logic [3:0] exp_an;
    logic [3:0] exp_bcd;
    logic [1:0] exp_sel;
    logic       exp_fs;

    display_scan_mux #(
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .digits      (digits),
        .blink_mask  (blink_mask),
        .blink_phase (blink_phase),
        .bcd_out     (bcd_out),
        .anode_n     (anode_n),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_reset();
        active = 1'b0;
        for (int i = 0; i < 4; i++) snap[i] = 4'd0;
        exp_an  = 4'hF;
        exp_bcd = 4'd0;
        exp_sel = 2'd0;
        exp_fs  = 1'b0;
    endtask

    // Model one clock edge: slot position comes from cycles since enable
    task automatic model_edge();
        if (rst) begin
            expect_reset();
        end else if (!en) begin
            active  = 1'b0;
            exp_an  = 4'hF;
            exp_sel = 2'd0;
            exp_bcd = snap[0];
            exp_fs  = 1'b0;
        end else begin
            if (!active) begin
                active = 1'b1;
                k = 0;
            end else begin
                k++;
            end
            pos_m = k % RD;
            idx_m = (k / RD) % 4;
            if (pos_m == 0) begin
                if (idx_m == 0)
                    for (int i = 0; i < 4; i++) snap[i] = digits[4*i +: 4];
                blank_m = blink_mask[idx_m] && blink_phase;
`ifdef LEADING_ZERO_BLANK_EN
                if (idx_m == 3 && snap[3] == 4'd0) blank_m = 1'b1;
`endif
            end
            exp_fs  = (pos_m == 0 && idx_m == 0);
            exp_sel = 2'(idx_m);
            exp_bcd = snap[idx_m];
            exp_an  = (pos_m < DC || blank_m) ? 4'hF
                                              : (4'hF ^ (4'h1 << idx_m));
        end
    endtask

    task automatic compare(input string ph);
        chk({ph, ".anode_n"}, 16'(anode_n), 16'(exp_an));
        chk({ph, ".digit_sel"}, 16'(digit_sel), 16'(exp_sel));
        chk({ph, ".bcd_out"}, 16'(bcd_out), 16'(exp_bcd));
        chk({ph, ".frame_start"}, 16'(frame_start), 16'(exp_fs));
        chk({ph, ".one_anode"}, 16'($countones(~anode_n) <= 1), 16'd1);
    endtask

    task automatic step(input string ph, input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            compare(ph);
        end
    endtask

    task automatic wait_slot(input int wi, input int wp);
        int n = 0;
        while (!(active && idx_m == wi && pos_m == wp) && n < 40) begin
            step("wait", 1);
            n++;
        end
        chk("wait_slot_timeout", 16'(n < 40), 16'd1);
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b1;
        digits      = 16'h1234;
        blink_mask  = 4'b0000;
        blink_phase = 1'b0;
        #1;
        expect_reset();
        compare("reset");
        step("reset", 2);

        rst = 1'b0;
        step("scan", 36);

        wait_slot(1, 1);
        digits = 16'h5678;
        step("snapshot", 24);

        blink_mask  = 4'b0011;
        blink_phase = 1'b1;
        step("blink_on", 32);
        blink_phase = 1'b0;
        step("blink_off", 20);
        blink_mask  = 4'b0000;

        digits = 16'h0930;
        step("lead_zero", 36);

        digits = 16'h2147;
        wait_slot(2, 2);
        en = 1'b0;
        step("en_drop", 3);
        en = 1'b1;
        step("en_restart", 20);

        wait_slot(1, 2);
        #2 rst = 1'b1;
        #1;
        expect_reset();
        compare("rst_mid");
        step("rst_hold", 1);
        rst = 1'b0;
        digits = 16'h8642;
        step("rst_restart", 20);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 11) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 5) == 0) blink_phase = 1'($urandom);
            en = ($urandom_range(0, 39) != 0);
            step("random", 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
